dmul_rot_bi_seq: RTL
====================

DMUL_ROT_BI_SEQ -- requirements
Module: dmul_rot_bi_seq

Interface
REQ-001 Parameter DATAWD, default 8: operand width; multiplier count width is 2*DATAWD.
REQ-002 Parameter WINLEN, default 65535: accumulate cycles per product; legal range 1..2^(2*DATAWD)-1, so the multiplier count never wraps.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  operand pair offered.
REQ-006 in_ready  out  1  sequencer accepts the pair this cycle.
REQ-007 in_a, in_b  in  DATAWD each  unipolar-coded operands.
REQ-008 mul_iA, mul_iB  out  DATAWD each  operands driven to the bipolar rotation multiplier.
REQ-009 mul_loadA, mul_loadB  out  1 each  multiplier load/clear strobes.
REQ-010 mul_oC  in  2*DATAWD  multiplier mismatch (XOR) count.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer takes the result.
REQ-013 out_cnt  out  2*DATAWD  raw captured mismatch count.
REQ-014 out_prod  out  2*DATAWD+2, signed  bipolar product = WINLEN - 2*out_cnt.
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, LOAD, RUN, CAPT; IDLE is the reset state.
REQ-017 in_ready = (state==IDLE) && !out_valid; a handshake is in_valid && in_ready.
REQ-018 IDLE -> LOAD on handshake; in_a/in_b are registered into mul_iA/mul_iB at that edge.
REQ-019 LOAD lasts exactly 1 cycle with mul_loadA = mul_loadB = 1; window counter is cleared; LOAD -> RUN.
REQ-020 mul_loadA/mul_loadB are 0 in every state other than LOAD.
REQ-021 RUN lasts exactly WINLEN cycles, counted by a window counter of 2*DATAWD bits; after the last RUN cycle the state goes RUN -> CAPT.
REQ-022 CAPT lasts 1 cycle: at its closing edge mul_oC is captured into out_cnt, out_prod is computed from it, out_valid is set, and the state goes CAPT -> IDLE.
REQ-023 Latency: for a handshake in cycle 0, LOAD is cycle 1, RUN is cycles 2..WINLEN+1, CAPT is cycle WINLEN+2, and out_valid is first high in cycle WINLEN+3.
REQ-024 Arithmetic: out_prod is computed sign-extended without saturation; the range -WINLEN..+WINLEN is exactly representable.
REQ-025 out_valid clears on the edge where out_valid && out_ready.
REQ-026 While out_valid && !out_ready, out_cnt and out_prod hold stable.
REQ-027 No new pair is accepted while out_valid is high, so CAPT never blocks and the multiplier never over-accumulates.
REQ-028 in_a/in_b are ignored outside handshakes; mul_iA/mul_iB hold between loads.

Reset
REQ-029 Asserting rst_n low, in any state including mid-RUN, forces within the same cycle: state IDLE, window counter 0, mul_iA/mul_iB 0, mul_loadA/mul_loadB 0, out_valid 0, out_cnt 0, out_prod 0, busy 0.
REQ-030 After reset release, in_ready is 1 on the first cycle; an aborted window produces no result.

Structure
REQ-031 Package dmul_pkg holds DATAWD, the state enum type, and the count and product width constants.
REQ-032 One sub-module, dmul_win_cnt, contains the window counter with clear and a terminal flag (count == WINLEN-1).
REQ-033 The multiplier is not instantiated here; it connects at the integration level.

Verification (WINLEN=16 unless stated; multiplier instantiated in the bench)
REQ-034 in_a=0, in_b=0 -> out_cnt=0, out_prod=+16, out_valid first high in cycle 19 after the handshake.
REQ-035 in_a=255, in_b=0 -> out_cnt=16, out_prod=-16.
REQ-036 Result present, out_ready held 0 for 10 cycles -> out_valid, out_cnt and out_prod stable, and in_ready=0 throughout.
REQ-037 rst_n pulsed low in RUN cycle 5 -> all outputs 0 immediately; in_ready=1 after release; no out_valid for the aborted pair.
REQ-038 in_valid held high for 3 pairs with out_ready=1 -> 3 results in order; each new handshake occurs only after the previous result's out_valid/out_ready handshake.
REQ-039 WINLEN=65535, in_a=0, in_b=0 -> out_prod=+65535 with no count wrap.

Source files
------------

// File: rtl/dmul_pkg.sv
// dmul_pkg -- shared definitions for the bipolar rotation-multiplier sequencer.
//   DATAWD  : default operand width
//   state_t : sequencer states (IDLE is the reset state)
//   cnt_w() / prod_w() : count and signed-product widths for a given operand width
//   CNT_W / PROD_W     : those widths at the default operand width
`timescale 1ns/1ps
package dmul_pkg;

    localparam int DATAWD = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        CAPT = 2'd3
    } state_t;

    // The mismatch count covers up to 2^(2*dw)-1 window cycles.
    function automatic int cnt_w(input int dw);
        return 2 * dw;
    endfunction

    // Two extra bits: one for the factor of two, one for the sign.
    function automatic int prod_w(input int dw);
        return 2 * dw + 2;
    endfunction

    localparam int CNT_W  = cnt_w(DATAWD);
    localparam int PROD_W = prod_w(DATAWD);

endpackage

// File: rtl/dmul_win_cnt.sv
// dmul_win_cnt -- accumulation window counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : advance the count by one
//   last       : high while the count equals WINLEN-1 (final window cycle)
`timescale 1ns/1ps
module dmul_win_cnt
#(
    parameter int CW     = dmul_pkg::cnt_w(dmul_pkg::DATAWD),
    parameter int WINLEN = 65535
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);
    import dmul_pkg::*;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // WINLEN never exceeds 2^CW-1, so WINLEN-1 always fits in CW bits.
    assign last = (cnt == CW'(WINLEN - 1));

endmodule

// File: rtl/dmul_rot_bi_seq.sv
// dmul_rot_bi_seq -- sequencer for an external bipolar rotation multiplier.
// Accepts one unipolar operand pair, loads it into the multiplier, lets the
// multiplier accumulate its XOR mismatch count for WINLEN cycles, then
// captures the count and converts it to the bipolar product WINLEN - 2*count.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand handshake; in_a, in_b operands
//   mul_iA, mul_iB        : operands held for the multiplier
//   mul_loadA, mul_loadB  : multiplier load/clear strobes (LOAD state only)
//   mul_oC                : multiplier mismatch count
//   out_valid/out_ready   : result handshake; out_cnt raw count, out_prod signed product
//   busy                  : sequencer not idle
`timescale 1ns/1ps
module dmul_rot_bi_seq
#(
    parameter int DATAWD = dmul_pkg::DATAWD,
    parameter int WINLEN = 65535
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATAWD-1:0]           in_a,
    input  logic [DATAWD-1:0]           in_b,
    output logic [DATAWD-1:0]           mul_iA,
    output logic [DATAWD-1:0]           mul_iB,
    output logic                        mul_loadA,
    output logic                        mul_loadB,
    input  logic [2*DATAWD-1:0]         mul_oC,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*DATAWD-1:0]         out_cnt,
    output logic signed [2*DATAWD+1:0]  out_prod,
    output logic                        busy
);
    import dmul_pkg::*;

    localparam int CW = cnt_w(DATAWD);
    localparam int PW = prod_w(DATAWD);

    state_t state, state_n;
    logic   load, cnt_clr, cnt_en, capt, accept, win_last;

    // WINLEN - 2*count, computed wide enough that -WINLEN..+WINLEN never overflows.
    function automatic logic signed [PW-1:0] bipolar_prod(input logic [CW-1:0] c);
        logic signed [PW-1:0] win;
        logic signed [PW-1:0] twice;
        win   = PW'(WINLEN);
        twice = $signed({1'b0, c, 1'b0});
        return win - twice;
    endfunction

    dmul_win_cnt #(
        .CW     (CW),
        .WINLEN (WINLEN)
    ) u_win_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .last  (win_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        capt     = 1'b0;
        // Holding off new pairs while a result is pending keeps CAPT non-blocking.
        in_ready = (state == IDLE) && !out_valid;
        accept   = in_valid && in_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                load    = 1'b1;
                cnt_clr = 1'b1;
                state_n = RUN;
            end
            RUN: begin
                cnt_en = 1'b1;
                if (win_last) begin
                    state_n = CAPT;
                end
            end
            CAPT: begin
                capt    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign mul_loadA = load;
    assign mul_loadB = load;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_iA    <= '0;
            mul_iB    <= '0;
            out_cnt   <= '0;
            out_prod  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                mul_iA <= in_a;
                mul_iB <= in_b;
            end
            // CAPT cannot coincide with a pending result, so set/clear never collide.
            if (capt) begin
                out_cnt   <= mul_oC;
                out_prod  <= bipolar_prod(mul_oC);
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
